// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the 32x32 register file: buffers datapath writes,
// retires one per cycle, and forwards pending data onto the read ports.
module rf_writeback_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [4:0]       wb_sel,
  input  logic [31:0]      wb_dat,
  input  logic [4:0]       rsel1,
  input  logic [4:0]       rsel2,
  output logic [31:0]      rdat1,
  output logic [31:0]      rdat2,
  output logic             rf_WEN,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic [4:0]       rf_rsel1,
  output logic [4:0]       rf_rsel2,
  input  logic [31:0]      rf_rdat1,
  input  logic [31:0]      rf_rdat2,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [4:0]       sel_r [DEPTH];
  logic [31:0]      dat_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic        push_s;
  logic        pop_s;
  logic [31:0] fwd1_s;
  logic [31:0] fwd2_s;

  // Register 0 writes consume the beat but never enter the queue.
  assign wb_ready = (count_r != CNT_FULL);
  assign push_s   = wb_valid && wb_ready && (wb_sel != 5'd0);
  assign pop_s    = (count_r != '0);

  assign rf_WEN   = pop_s;
  assign rf_wsel  = pop_s ? sel_r[head_r] : 5'd0;
  assign rf_wdat  = pop_s ? dat_r[head_r] : 32'd0;
  assign rf_rsel1 = rsel1;
  assign rf_rsel2 = rsel2;
  assign count    = count_r;

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      vld_r   <= '0;
    end else begin
      if (push_s) begin
        vld_r[tail_r] <= 1'b1;
        tail_r        <= tail_r + 1'b1;
      end
      if (pop_s) begin
        vld_r[head_r] <= 1'b0;
        head_r        <= head_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage; guarded by vld_r so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      sel_r[tail_r] <= wb_sel;
      dat_r[tail_r] <= wb_dat;
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    fwd1_s = rf_rdat1;
    fwd2_s = rf_rdat2;
    for (int i = 0; i < DEPTH; i++) begin
      fwd1_s = (vld_r[head_r + PTR_W'(i)] && (sel_r[head_r + PTR_W'(i)] == rsel1))
               ? dat_r[head_r + PTR_W'(i)] : fwd1_s;
      fwd2_s = (vld_r[head_r + PTR_W'(i)] && (sel_r[head_r + PTR_W'(i)] == rsel2))
               ? dat_r[head_r + PTR_W'(i)] : fwd2_s;
    end
    if (rsel1 == 5'd0) begin
      rdat1 = 32'd0;
    end else begin
      rdat1 = fwd1_s;
    end
    if (rsel2 == 5'd0) begin
      rdat2 = 32'd0;
    end else begin
      rdat2 = fwd2_s;
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: a vector table for single-cycle behaviour,
// plus hand sequences for async reset mid-drain and a DEPTH=2 ordering run.
module tb_rf_writeback_queue;

  typedef struct {
    logic        v;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic [4:0]  rs1;
    logic [31:0] rr1;
    logic [4:0]  rs2;
    logic [31:0] rr2;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [2:0]  cnt;
  } vec_t;

  logic        CLK;
  logic        nRST;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_sel, rsel1, rsel2, rf_wsel, rf_rsel1, rf_rsel2;
  logic [31:0] wb_dat, rdat1, rdat2, rf_wdat, rf_rdat1, rf_rdat2;
  logic        rf_WEN;
  logic [2:0]  count;

  logic        v2, rdy2, wen2;
  logic [4:0]  sel2, wsel2, rs1_2, rs2_2;
  logic [31:0] dat2, wdat2, rd1_2, rd2_2;
  logic [1:0]  cnt2;

  int tests  = 0;
  int failed = 0;
  vec_t vecs[$];

  rf_writeback_queue #(.DEPTH(4)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_sel(wb_sel), .wb_dat(wb_dat),
    .rsel1(rsel1), .rsel2(rsel2), .rdat1(rdat1), .rdat2(rdat2),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
    .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2), .count(count)
  );

  rf_writeback_queue #(.DEPTH(2)) u_dut2 (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(v2), .wb_ready(rdy2), .wb_sel(sel2), .wb_dat(dat2),
    .rsel1(5'd0), .rsel2(5'd0), .rdat1(rd1_2), .rdat2(rd2_2),
    .rf_WEN(wen2), .rf_wsel(wsel2), .rf_wdat(wdat2),
    .rf_rsel1(rs1_2), .rf_rsel2(rs2_2),
    .rf_rdat1(32'd0), .rf_rdat2(32'd0), .count(cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] sel, input logic [31:0] dat,
                     input logic [4:0] rs1, input logic [31:0] rr1,
                     input logic [4:0] rs2, input logic [31:0] rr2,
                     input logic wen, input logic [4:0] wsel, input logic [31:0] wdat,
                     input logic [31:0] rd1, input logic [31:0] rd2, input logic [2:0] cnt);
    vec_t t;
    t.v = v; t.sel = sel; t.dat = dat; t.rs1 = rs1; t.rr1 = rr1; t.rs2 = rs2; t.rr2 = rr2;
    t.wen = wen; t.wsel = wsel; t.wdat = wdat; t.rd1 = rd1; t.rd2 = rd2; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [4:0] sel, input logic [31:0] dat,
                       input logic [4:0] rs1, input logic [31:0] rr1,
                       input logic [4:0] rs2, input logic [31:0] rr2);
    wb_valid = v; wb_sel = sel; wb_dat = dat;
    rsel1 = rs1; rf_rdat1 = rr1; rsel2 = rs2; rf_rdat2 = rr2;
  endtask

  initial begin
    logic [36:0] exp_q[$];
    logic [36:0] head_e;
    int beat, cyc, max_cnt;

    drive(1'b0, 5'd0, 32'd0, 5'd5, 32'h55, 5'd0, 32'd0);
    v2 = 1'b0; sel2 = 5'd0; dat2 = 32'd0;
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_wen", {31'd0, rf_WEN}, 32'd0);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);
    nRST = 1'b1;

    // v sel dat | rs1 rr1 rs2 rr2 || wen wsel wdat rd1 rd2 cnt
    add(1'b0, 5'd0, 32'h0,        5'd5, 32'h55,       5'd0, 32'h99, 1'b0, 5'd0, 32'h0,        32'h55,       32'h0,    3'd0);
    add(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 32'h77,       5'd0, 32'h99, 1'b0, 5'd0, 32'h0,        32'h77,       32'h0,    3'd0);
    add(1'b0, 5'd0, 32'h0,        5'd3, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,    3'd1);
    add(1'b0, 5'd0, 32'h0,        5'd3, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,    3'd0);
    add(1'b1, 5'd1, 32'h11,       5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        32'h0,        32'h0,    3'd0);
    add(1'b1, 5'd2, 32'h22,       5'd1, 32'h0,        5'd0, 32'h0,  1'b1, 5'd1, 32'h11,       32'h11,       32'h0,    3'd1);
    add(1'b1, 5'd3, 32'h33,       5'd0, 32'h0,        5'd2, 32'h0,  1'b1, 5'd2, 32'h22,       32'h0,        32'h22,   3'd1);
    add(1'b1, 5'd4, 32'h44,       5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 32'h33,       32'h0,        32'h0,    3'd1);
    add(1'b0, 5'd0, 32'h0,        5'd4, 32'h0,        5'd0, 32'h0,  1'b1, 5'd4, 32'h44,       32'h44,       32'h0,    3'd1);
    add(1'b0, 5'd0, 32'h0,        5'd4, 32'h44,       5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        32'h44,       32'h0,    3'd0);
    add(1'b1, 5'd7, 32'hA,        5'd0, 32'h0,        5'd7, 32'h0,  1'b0, 5'd0, 32'h0,        32'h0,        32'h0,    3'd0);
    add(1'b1, 5'd7, 32'hB,        5'd0, 32'h0,        5'd7, 32'h0,  1'b1, 5'd7, 32'hA,        32'h0,        32'hA,    3'd1);
    add(1'b0, 5'd0, 32'h0,        5'd5, 32'h55,       5'd7, 32'hA,  1'b1, 5'd7, 32'hB,        32'h55,       32'hB,    3'd1);
    add(1'b0, 5'd0, 32'h0,        5'd0, 32'h0,        5'd7, 32'hB,  1'b0, 5'd0, 32'h0,        32'h0,        32'hB,    3'd0);
    add(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h1234,     5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        32'h0,        32'h0,    3'd0);
    add(1'b0, 5'd0, 32'h0,        5'd0, 32'h1234,     5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        32'h0,        32'h0,    3'd0);
    add(1'b1, 5'd9, 32'hC0FFEE,   5'd9, 32'h0,        5'd9, 32'h0,  1'b0, 5'd0, 32'h0,        32'h0,        32'h0,    3'd0);
    add(1'b0, 5'd0, 32'h0,        5'd9, 32'h0,        5'd9, 32'h1,  1'b1, 5'd9, 32'hC0FFEE,   32'hC0FFEE,   32'hC0FFEE, 3'd1);

    foreach (vecs[k]) begin
      @(negedge CLK);
      drive(vecs[k].v, vecs[k].sel, vecs[k].dat, vecs[k].rs1, vecs[k].rr1, vecs[k].rs2, vecs[k].rr2);
      #1;
      chk($sformatf("v%0d_wen", k),   {31'd0, rf_WEN},  {31'd0, vecs[k].wen});
      chk($sformatf("v%0d_wsel", k),  {27'd0, rf_wsel}, {27'd0, vecs[k].wsel});
      chk($sformatf("v%0d_wdat", k),  rf_wdat,          vecs[k].wdat);
      chk($sformatf("v%0d_rdat1", k), rdat1,            vecs[k].rd1);
      chk($sformatf("v%0d_rdat2", k), rdat2,            vecs[k].rd2);
      chk($sformatf("v%0d_count", k), {29'd0, count},   {29'd0, vecs[k].cnt});
      chk($sformatf("v%0d_ready", k), {31'd0, wb_ready}, 32'd1);
      chk($sformatf("v%0d_rsel", k),  {22'd0, rf_rsel1, rf_rsel2}, {22'd0, vecs[k].rs1, vecs[k].rs2});
    end

    // Async reset while a write is pending at the head.
    @(negedge CLK); drive(1'b1, 5'd10, 32'h100, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge CLK); drive(1'b1, 5'd11, 32'h101, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge CLK); drive(1'b1, 5'd12, 32'h102, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge CLK); drive(1'b0, 5'd0, 32'h0, 5'd12, 32'h5A5A, 5'd11, 32'h6B6B);
    #1;
    chk("mid_wen_before", {31'd0, rf_WEN}, 32'd1);
    chk("mid_fwd_before", rdat1, 32'h102);
    #1 nRST = 1'b0;
    #1;
    chk("mid_wen_async", {31'd0, rf_WEN}, 32'd0);
    chk("mid_count_async", {29'd0, count}, 32'd0);
    chk("mid_rdat1_pass", rdat1, 32'h5A5A);
    chk("mid_rdat2_pass", rdat2, 32'h6B6B);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK); #1;
    chk("post_rst_wen", {31'd0, rf_WEN}, 32'd0);
    chk("post_rst_count", {29'd0, count}, 32'd0);
    chk("post_rst_rdat1", rdat1, 32'h5A5A);

    // DEPTH=2 with wb_valid held high: order, bound and ready/count relation.
    beat = 0; max_cnt = 0;
    for (cyc = 0; cyc < 60 && (beat < 12 || exp_q.size() != 0); cyc++) begin
      @(negedge CLK);
      v2 = (beat < 12); sel2 = 5'((beat % 8) + 1); dat2 = 32'h200 + 32'(beat);
      #1;
      if (int'(cnt2) > max_cnt) max_cnt = int'(cnt2);
      chk("d2_cnt_bound", {31'd0, (cnt2 <= 2'd2)}, 32'd1);
      chk("d2_ready_vs_full", {31'd0, rdy2}, {31'd0, (cnt2 != 2'd2)});
      if (wen2) begin
        if (exp_q.size() == 0) begin
          chk("d2_retire_unexpected", {27'd0, wsel2}, 32'hFFFFFFFF);
        end else begin
          head_e = exp_q.pop_front();
          chk("d2_retire", {wsel2, wdat2}, head_e);
        end
      end
      if (v2 && rdy2) begin
        exp_q.push_back({sel2, dat2});
        beat++;
      end
    end
    chk("d2_all_beats_pushed", beat, 12);
    chk("d2_all_retired", exp_q.size(), 0);
    chk("d2_count_peak", max_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
